// File: rtl/scie_fir_engine.sv
// Custom-instruction FIR engine: TAPS-deep coefficient bank and delay line,
// one multiply-accumulate per cycle, with selectable rounding and saturation.
module scie_fir_engine #(
    parameter int XLEN      = 32,
    parameter int DATA_W    = 16,
    parameter int TAPS      = 8,
    parameter int FRAC_BITS = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    output logic            io_ready,
    input  logic [31:0]     io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic [XLEN-1:0] io_rd,
    output logic            io_rd_valid
);

    localparam int ACC_W  = 2*DATA_W + $clog2(TAPS);
    localparam int KW     = $clog2(TAPS);
    localparam int EXT_W  = ((ACC_W > XLEN) ? ACC_W : XLEN) + 1;
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

    localparam logic signed [EXT_W-1:0] RND_INC =
        (FRAC_BITS > 0) ? (EXT_W'(1) << RND_SH) : {EXT_W{1'b0}};
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({1'b0, {(XLEN-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    localparam logic [6:0] OP_SETC    = 7'h0B;
    localparam logic [6:0] OP_PUSH    = 7'h2B;
    localparam logic [6:0] OP_COMPUTE = 7'h5B;
    localparam logic [6:0] OP_CLEAR   = 7'h7B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic signed [DATA_W-1:0]   coeff_r [TAPS];
    logic signed [DATA_W-1:0]   x_r     [TAPS];
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [KW-1:0]              k_r;
    logic [1:0]                 mode_r;
    logic [XLEN-1:0]            rd_r;
    logic                       rd_valid_r;
    logic                       ready_r;
    logic                       accept_s;
    logic [6:0]                 opcode_s;
    logic                       unused_s;

    // mode[0] rounds, mode[1] saturates; otherwise the low XLEN bits wrap.
    function automatic logic [XLEN-1:0] form_result(
        input logic signed [ACC_W-1:0] acc,
        input logic [1:0]              mode
    );
        logic signed [EXT_W-1:0] v;
        logic [XLEN-1:0]         res;
        v = EXT_W'(acc);
        if (mode[0]) begin
            v = v + RND_INC;
        end
        v = v >>> FRAC_BITS;
        if (mode[1]) begin
            if (v > SAT_MAX) begin
                res = SAT_MAX[XLEN-1:0];
            end else if (v < SAT_MIN) begin
                res = SAT_MIN[XLEN-1:0];
            end else begin
                res = v[XLEN-1:0];
            end
        end else begin
            res = v[XLEN-1:0];
        end
        return res;
    endfunction

    assign accept_s    = io_valid && ready_r;
    assign opcode_s    = io_insn[6:0];
    assign prod_s      = (2*DATA_W)'(coeff_r[k_r]) * (2*DATA_W)'(x_r[k_r]);
    assign io_ready    = ready_r;
    assign io_rd       = rd_r;
    assign io_rd_valid = rd_valid_r;
    assign unused_s    = ^{io_insn[31:14], io_insn[11:7], io_rs1[XLEN-1:DATA_W]};

    // Next-state decode for the IDLE -> COMPUTE -> DONE sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (opcode_s == OP_COMPUTE)) begin
                    next_state_s = ST_COMPUTE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (k_r == K_LAST) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_COMPUTE;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction execution, MAC datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coeff_r[i] <= '0;
                x_r[i]     <= '0;
            end
            acc_r      <= '0;
            k_r        <= '0;
            mode_r     <= 2'b00;
            rd_r       <= '0;
            rd_valid_r <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
            ready_r    <= (next_state_s == ST_IDLE);
            if (accept_s) begin
                case (opcode_s)
                    OP_SETC: begin
                        for (int i = 0; i < TAPS; i++) begin
                            if (io_rs2 == XLEN'(i)) begin
                                coeff_r[i] <= io_rs1[DATA_W-1:0];
                            end
                        end
                    end
                    OP_PUSH: begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            x_r[i] <= x_r[i-1];
                        end
                        x_r[0] <= io_rs1[DATA_W-1:0];
                    end
                    OP_COMPUTE: begin
                        mode_r <= io_insn[13:12];
                        acc_r  <= '0;
                        k_r    <= '0;
                    end
                    OP_CLEAR: begin
                        for (int i = 0; i < TAPS; i++) begin
                            x_r[i] <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (state_r == ST_COMPUTE) begin
                acc_r <= acc_r + ACC_W'(prod_s);
                k_r   <= k_r + KW'(1);
            end
            if (state_r == ST_DONE) begin
                rd_r       <= form_result(acc_r, mode_r);
                rd_valid_r <= 1'b1;
            end
        end
    end

endmodule
